rename_queue: RTL

- Circular FIFO that takes decoded instruction bundles from the decode stage and holds them until the rename stage consumes them.
- Decode pushes with RNMQ_NQ and is throttled by RNMQ_full.
- Rename pops with DQ_IN and reads the head entry as show-ahead.
- Decode registers its enqueue one cycle after it samples RNMQ_full, so the full flag carries one slot of slack.

---
 rtl/rename_queue.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/rename_queue.sv
// Decode-to-rename circular FIFO with a show-ahead head entry.
// Latency: an entry written at edge N is visible on the head outputs after edge N.
// Backpressure: RNMQ_full rises one slot early; an enqueue at count==DEPTH is dropped and sets OVERFLOW_OUT.
//
// Ports:
//   CLK, RESET (async active-low), FLUSH (sync squash, highest priority)
//   RNMQ_NQ + *_IN bundle fields : enqueue from decode
//   DQ_IN                        : dequeue from rename
//   *_OUT bundle fields          : head entry, all zero while empty
//   RNMQ_full, EMPTY_OUT, COUNT_OUT, OVERFLOW_OUT : status
// Optional: define RNMQ_STATS_EN to add STAT_NQ_OUT, STAT_DQ_OUT, STAT_FULL_CYC_OUT.
module rename_queue #(
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              FLUSH,
   input  logic              RNMQ_NQ,
   input  logic [31:0]       Instr_IN,
   input  logic [31:0]       Instr_PC_IN,
   input  logic [31:0]       Instr_PC_Plus4_IN,
   input  logic [4:0]        ReadRegisterA_IN,
   input  logic [4:0]        ReadRegisterB_IN,
   input  logic [4:0]        WriteRegister_IN,
   input  logic              RegWrite_IN,
   input  logic [5:0]        ALU_Control_IN,
   input  logic              MemRead_IN,
   input  logic              MemWrite_IN,
   input  logic [4:0]        ShiftAmount_IN,
   input  logic [8:0]        Instr_Flags_IN,
   input  logic              DQ_IN,
   output logic              RNMQ_full,
   output logic              EMPTY_OUT,
   output logic [ADDR_W:0]   COUNT_OUT,
   output logic              OVERFLOW_OUT,
`ifdef RNMQ_STATS_EN
   output logic [31:0]       STAT_NQ_OUT,
   output logic [31:0]       STAT_DQ_OUT,
   output logic [31:0]       STAT_FULL_CYC_OUT,
`endif
   output logic [31:0]       Instr_OUT,
   output logic [31:0]       Instr_PC_OUT,
   output logic [31:0]       Instr_PC_Plus4_OUT,
   output logic [4:0]        ReadRegisterA_OUT,
   output logic [4:0]        ReadRegisterB_OUT,
   output logic [4:0]        WriteRegister_OUT,
   output logic              RegWrite_OUT,
   output logic [5:0]        ALU_Control_OUT,
   output logic              MemRead_OUT,
   output logic              MemWrite_OUT,
   output logic [4:0]        ShiftAmount_OUT,
   output logic [8:0]        Instr_Flags_OUT
);

   // 134-bit bundle
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pc4;
      logic [4:0]  ra;
      logic [4:0]  rb;
      logic [4:0]  wr;
      logic        reg_write;
      logic [5:0]  alu;
      logic        mem_read;
      logic        mem_write;
      logic [4:0]  shamt;
      logic [8:0]  flags;
   } entry_t;

   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] FULL_C  = DEPTH_C - 1'b1;

   entry_t            mem [DEPTH];
   entry_t            in_e;
   entry_t            head_e;
   logic [ADDR_W-1:0] head;
   logic [ADDR_W-1:0] tail;
   logic [ADDR_W:0]   count;
   logic              ovf;
   logic              empty;
   logic              dq_acc;
   logic              nq_acc;

   assign in_e = '{instr: Instr_IN, pc: Instr_PC_IN, pc4: Instr_PC_Plus4_IN,
                   ra: ReadRegisterA_IN, rb: ReadRegisterB_IN, wr: WriteRegister_IN,
                   reg_write: RegWrite_IN, alu: ALU_Control_IN, mem_read: MemRead_IN,
                   mem_write: MemWrite_IN, shamt: ShiftAmount_IN, flags: Instr_Flags_IN};

   assign empty  = (count == '0);
   assign dq_acc = DQ_IN & ~empty;
   // A full queue still accepts when the head leaves in the same cycle.
   assign nq_acc = RNMQ_NQ & ((count < DEPTH_C) | dq_acc);

   assign RNMQ_full    = (count >= FULL_C);
   assign EMPTY_OUT    = empty;
   assign COUNT_OUT    = count;
   assign OVERFLOW_OUT = ovf;

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         ovf   <= 1'b0;
      end else if (FLUSH) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         ovf   <= 1'b0;
      end else begin
         if (dq_acc) head <= head + ADDR_W'(1);
         if (nq_acc) tail <= tail + ADDR_W'(1);
         case ({nq_acc, dq_acc})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (RNMQ_NQ && !nq_acc) ovf <= 1'b1;
      end
   end

   // Storage carries no reset; emptiness is tracked by count alone.
   always_ff @(posedge CLK) begin
      if (nq_acc && !FLUSH) mem[tail] <= in_e;
   end

   // Empty queue presents an all-zero NOP bundle.
   assign head_e = empty ? '0 : mem[head];

   assign Instr_OUT          = head_e.instr;
   assign Instr_PC_OUT       = head_e.pc;
   assign Instr_PC_Plus4_OUT = head_e.pc4;
   assign ReadRegisterA_OUT  = head_e.ra;
   assign ReadRegisterB_OUT  = head_e.rb;
   assign WriteRegister_OUT  = head_e.wr;
   assign RegWrite_OUT       = head_e.reg_write;
   assign ALU_Control_OUT    = head_e.alu;
   assign MemRead_OUT        = head_e.mem_read;
   assign MemWrite_OUT       = head_e.mem_write;
   assign ShiftAmount_OUT    = head_e.shamt;
   assign Instr_Flags_OUT    = head_e.flags;

`ifdef RNMQ_STATS_EN
   // Statistics survive FLUSH; only RESET clears them.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         STAT_NQ_OUT       <= '0;
         STAT_DQ_OUT       <= '0;
         STAT_FULL_CYC_OUT <= '0;
      end else begin
         if (nq_acc && !FLUSH) STAT_NQ_OUT <= STAT_NQ_OUT + 32'd1;
         if (dq_acc && !FLUSH) STAT_DQ_OUT <= STAT_DQ_OUT + 32'd1;
         if (RNMQ_full)        STAT_FULL_CYC_OUT <= STAT_FULL_CYC_OUT + 32'd1;
      end
   end
`endif

endmodule
